// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver (8-N-1) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames with even-parity checking.

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_ADDR_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       overflow,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** FIFO_ADDR_W;

    localparam logic [CNT_W-1:0]     CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_W:0] FIFO_FULL = {1'b1, {FIFO_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and previous-sample register
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two-flop synchronizer into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_q      <= rx_s_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_q && !rx_s_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s_q) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_bit_d = rx_s_q;
                    cnt_d     = CNT_FULL;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit lets a start edge right after the stop bit be caught.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame outcome (FSM outputs) and FIFO control
    // ------------------------------------------------------------------
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]   count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d;
    logic                   par_bad;
`endif
    logic                   stop_sample;
    logic                   good_byte;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);

    always_comb begin
        stop_sample  = (state_q == S_STOP) && (cnt_q == '0);
        frame_err_d  = stop_sample && !rx_s_q;
`ifdef UART_RX_PARITY_EN
        // A framing error takes priority, so parity is judged only on a good stop bit.
        par_bad      = (par_bit_q != ^shift_q);
        parity_err_d = stop_sample && rx_s_q && par_bad;
        good_byte    = stop_sample && rx_s_q && !par_bad;
`else
        good_byte    = stop_sample && rx_s_q;
`endif
        pop          = rd_en && !fifo_empty;
        push         = good_byte && (!fifo_full || pop);
        overflow_d   = good_byte && fifo_full && !pop;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    logic [7:0] mem [DEPTH];

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and count define which entries are valid, and the output is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign empty     = fifo_empty;
    assign rd_data   = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; good frames go into a scoreboard queue
// and are compared as they are popped from the FIFO.

module tb_uart_rx;

    localparam int CPB = 16;
    localparam int FAW = 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 171;
`else
    localparam int STOP_EDGE = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_ADDR_W (FAW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .overflow  (overflow),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         fe0, ov0, pe0;
    logic [3:0] pre_v, at_v, post_v;
    logic [7:0] pre_data;
    logic [7:0] head;

    // Pulse-cycle counters: a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (overflow)   ov_cnt <= ov_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx = p;
        repeat (CPB) @(posedge clk);
        #1;
`endif
        rx = s;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Sends a frame and snapshots {empty,overflow,frame_err,parity_err} one cycle
    // before, at, and after the stop-sample edge; optionally pops on that edge.
    task automatic probe(input logic [7:0] d, input logic p, input logic s, input logic do_pop);
        fork
            send_frame(d, p, s);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                if (do_pop) begin
                    #1;
                    rd_en = 1'b1;
                end
                @(negedge clk);
                pre_v    = {empty, overflow, frame_err, parity_err};
                pre_data = rd_data;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
                @(negedge clk);
                at_v = {empty, overflow, frame_err, parity_err};
                @(negedge clk);
                post_v = {empty, overflow, frame_err, parity_err};
            end
        join
    endtask

    task automatic gap(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_byte(input string tag);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        @(negedge clk);
        check({tag, "_not_empty"}, empty, 1'b0);
        check({tag, "_data"}, rd_data, exp);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        @(negedge clk);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_rd_data_masked"}, rd_data, 8'h00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_pulses", {overflow, frame_err, parity_err}, 3'b000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        gap(10);

        // Single byte with exact empty timing
        exp_q.push_back(8'hA5);
        probe(8'hA5, ^8'hA5, 1'b1, 1'b0);
        check("single_pre", pre_v, 4'b1000);
        check("single_pre_data", pre_data, 8'h00);
        check("single_at", at_v, 4'b0000);
        check("single_post", post_v, 4'b0000);
        read_byte("single");
        expect_empty("single_after_pop");

        // Glitch rejection
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gap(40);
        expect_empty("glitch");
        check("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

        // Framing error, then recovery
        fe0 = fe_cnt; pe0 = pe_cnt;
        probe(8'h3C, ^8'h3C, 1'b0, 1'b0);
        check("frame_pre", pre_v, 4'b1000);
        check("frame_at", at_v, 4'b1010);
        check("frame_post", post_v, 4'b1000);
        gap(20);
        check("frame_err_width", fe_cnt - fe0, 1);
        check("frame_no_parity_err", pe_cnt - pe0, 0);
        exp_q.push_back(8'h55);
        probe(8'h55, ^8'h55, 1'b1, 1'b0);
        check("recover_at", at_v, 4'b0000);
        read_byte("recover");
        expect_empty("recover_after_pop");

        // Overflow and ordering
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            probe(8'(i), ^(8'(i)), 1'b1, 1'b0);
            gap(4);
        end
        ov0 = ov_cnt;
        probe(8'h05, ^8'h05, 1'b1, 1'b0);
        check("ovf_pre", pre_v, 4'b0000);
        check("ovf_at", at_v, 4'b0100);
        check("ovf_post", post_v, 4'b0000);
        gap(4);
        check("ovf_count", ov_cnt - ov0, 1);
        for (int i = 0; i < 4; i++) read_byte("ovf_order");
        expect_empty("ovf_drained");

        // Push and pop on the same edge with the FIFO full
        for (int i = 8'h11; i <= 8'h14; i++) begin
            exp_q.push_back(8'(i));
            probe(8'(i), ^(8'(i)), 1'b1, 1'b0);
            gap(4);
        end
        ov0 = ov_cnt;
        head = exp_q.pop_front();
        exp_q.push_back(8'h15);
        probe(8'h15, ^8'h15, 1'b1, 1'b1);
        check("simul_head", pre_data, head);
        check("simul_at", at_v, 4'b0000);
        gap(4);
        check("simul_no_ovf", ov_cnt - ov0, 0);
        for (int i = 0; i < 4; i++) read_byte("simul_order");
        expect_empty("simul_drained");

        // Reset during data bit 3
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                repeat (70) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        gap(10);
        expect_empty("rst_mid_frame");
        exp_q.push_back(8'h81);
        probe(8'h81, ^8'h81, 1'b1, 1'b0);
        check("rst_mid_at", at_v, 4'b0000);
        read_byte("rst_mid");
        expect_empty("rst_mid_after_pop");
        check("rst_mid_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity
        exp_q.push_back(8'h07);
        probe(8'h07, 1'b1, 1'b1, 1'b0);
        check("par_good_at", at_v, 4'b0000);
        read_byte("par_good");
        pe0 = pe_cnt;
        probe(8'h07, 1'b0, 1'b1, 1'b0);
        check("par_bad_at", at_v, 4'b1001);
        check("par_bad_post", post_v, 4'b1000);
        gap(4);
        check("par_bad_count", pe_cnt - pe0, 1);
        expect_empty("par_bad");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
